ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one port of the dual-port 48-bit state/Q-value RAM between NUM_REQ requesters (e.g. env stepper, agent, host loader).
- Issues registered single-word read/write commands with the RAM's active-low write strobe.
- Returns read data tagged with the requester id.
- Provides a clear sequence that sweeps every RAM address to zero on demand, without a global reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of requester id; must satisfy 2**ID_WIDTH >= NUM_REQ.
- ADDR_WIDTH, 10, RAM address width.
- DATA_WIDTH, 48, RAM word width.

Ports:
- i_clk  in  1  clock; single clock domain.
- i_rstn  in  1  asynchronous active-low reset.
- i_req  in  NUM_REQ  per-requester request, held high until acked.
- i_we  in  NUM_REQ  per-requester op: 1=write, 0=read; valid with i_req.
- i_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing.
- o_ack  out  NUM_REQ  one-hot accept pulse.
- o_rvalid  out  1  read data valid.
- o_rid  out  ID_WIDTH  requester id of returning read.
- o_rdata  out  DATA_WIDTH  read data; direct from i_ram_rdata, meaningful only when o_rvalid=1.
- i_clear  in  1  single-cycle pulse requesting a full-RAM zero sweep.
- o_busy  out  1  clear pending or in progress.
- o_ram_wr_n  out  1  RAM write enable, active low.
- o_ram_addr  out  ADDR_WIDTH  RAM address.
- o_ram_wdata  out  DATA_WIDTH  RAM write data.
- i_ram_rdata  in  DATA_WIDTH  RAM registered read data; one-cycle latency after address.

Behaviour:
- Reset (async, i_rstn=0): all registered outputs take their reset values, state=IDLE, clear_pending=0, rr pointer last=NUM_REQ-1 (requester 0 wins first).
  - o_ack=0, o_ram_wr_n=1, o_ram_addr=0, o_ram_wdata=0, o_rvalid=0, o_rid=0, o_busy=0.
- FSM states: IDLE, CLEAR.
- IDLE:
  - If clear_pending=1: go to CLEAR; no ack this cycle.
  - Else arbitrate combinationally: first requester with i_req=1 searching from last+1 upward, modulo NUM_REQ.
  - Winner k: o_ack[k]=1 in the same cycle (T); last<=k.
  - At edge T the command registers load o_ram_addr=addr_k, o_ram_wdata=wdata_k, o_ram_wr_n=~we_k.
  - With no winner: o_ram_wr_n<=1; addr/wdata hold.
- One grant per cycle; back-to-back grants to different or same requesters allowed every cycle.
- A requester seeing o_ack in cycle T either drops i_req or presents its next command from T+1.
- Read latency:
  - Ack in cycle T, RAM command in T+1, o_rvalid=1 and o_rid=k in T+2, for exactly one cycle.
  - o_rvalid/o_rid are a 2-stage registered pipeline; o_rdata=i_ram_rdata combinationally.
- Writes produce no o_rvalid.
- A read acked the cycle after a write to the same address returns the new data; ordering is preserved by the single port.
- Fairness: the most recent winner has lowest priority next cycle. Any continuously requesting requester is acked within NUM_REQ arbitration cycles.
- i_clear: sampled every cycle; sets clear_pending; o_busy<=1 from the next cycle.
  - i_clear while clear_pending=1 or state=CLEAR is ignored (no extension, no restart).
  - A request arriving in the same cycle as i_clear is still arbitrated that cycle; the clear is taken on the following cycle.
- CLEAR:
  - No acks. Issue writes o_ram_wr_n=0, o_ram_wdata=0, o_ram_addr=0,1,...,2**ADDR_WIDTH-1, one per cycle (2**ADDR_WIDTH cycles).
  - Clear counter is ADDR_WIDTH+1 bits, so the last address does not wrap into a false termination.
  - After the last address is issued: o_ram_wr_n<=1, state<=IDLE, clear_pending<=0, o_busy<=0.
  - Arbitration resumes the following cycle with the rr pointer unchanged.
- Reads acked before CLEAR entry still complete: o_rvalid in T+2 with pre-clear data.
- Reset mid-operation: everything returns to reset values immediately. In-flight reads are dropped (no o_rvalid); a partial clear is abandoned.
- This block never asserts o_ram_wr_n=0 while i_rstn=0.

Test Plan:
- Single read: all requesters idle, requester 2 reads addr 0x005 preloaded with 48'h0000_1234_5678 -> o_ack=4'b0100 at T; o_rvalid=1, o_rid=2, o_rdata=48'h0000_1234_5678 at T+2, for one cycle.
- Round robin: all four hold i_req=1 (reads) for 8 cycles after reset -> ack order 0,1,2,3,0,1,2,3; o_rid sequence identical, shifted 2 cycles.
- Write then read: requester 1 writes 48'hABCD_0000_0001 to 0x3FF, then reads 0x3FF in the next cycle -> o_rid=1, o_rdata=48'hABCD_0000_0001.
- Clear: i_clear pulse with requester 0 requesting.
  - Requester 0 is acked that cycle; o_busy is high for 1025 cycles.
  - o_ram_wr_n is low for exactly 1024 consecutive cycles, addresses 0..1023 with wdata 0.
  - No acks during the sweep; requester 0 is acked the first cycle after o_busy falls. A read of 0x3FF afterwards returns 0.
- Clear ignored: second i_clear 100 cycles into the sweep -> sweep still ends at the same cycle as in the previous scenario.
- Reset mid-op: i_rstn low one cycle after a read ack -> no o_rvalid; all outputs at reset values asynchronously; after release, requester 0 has first priority.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NUM_REQ requesters, with an
// on-demand sweep that writes zero to every RAM address.
module ram_port_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 48
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic [NUM_REQ-1:0]              i_req,
    input  logic [NUM_REQ-1:0]              i_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_wdata,
    output logic [NUM_REQ-1:0]              o_ack,
    output logic                            o_rvalid,
    output logic [ID_WIDTH-1:0]             o_rid,
    output logic [DATA_WIDTH-1:0]           o_rdata,
    input  logic                            i_clear,
    output logic                            o_busy,
    output logic                            o_ram_wr_n,
    output logic [ADDR_WIDTH-1:0]           o_ram_addr,
    output logic [DATA_WIDTH-1:0]           o_ram_wdata,
    input  logic [DATA_WIDTH-1:0]           i_ram_rdata
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                  state_q, state_d;
    logic                    clear_pending_q, clear_pending_d;
    logic [ID_WIDTH-1:0]     last_q, last_d;
    logic [ADDR_WIDTH:0]     clr_cnt_q, clr_cnt_d;
    logic                    rd_v1_q, rd_v1_d;
    logic [ID_WIDTH-1:0]     rid1_q, rid1_d;
    logic                    wr_n_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   wdata_d;

    logic                    grant;
    logic                    arb_en;
    logic [ID_WIDTH-1:0]     win;
    logic [ID_WIDTH-1:0]     idx;

    // Search from last+1 upward so the most recent winner has lowest priority.
    always_comb begin
        grant = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = ID_WIDTH'((32'(last_q) + i) % NUM_REQ);
            if (!grant && i_req[idx]) begin
                grant = 1'b1;
                win   = idx;
            end
        end
    end

    assign arb_en = (state_q == StIdle) && !clear_pending_q && grant;

    always_comb begin
        o_ack = '0;
        if (arb_en && i_rstn) begin
            o_ack[win] = 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        clear_pending_d = clear_pending_q;
        last_d          = last_q;
        clr_cnt_d       = clr_cnt_q;
        rd_v1_d         = 1'b0;
        rid1_d          = rid1_q;
        wr_n_d          = 1'b1;
        addr_d          = o_ram_addr;
        wdata_d         = o_ram_wdata;
        case (state_q)
            StIdle: begin
                if (clear_pending_q) begin
                    // The transition cycle already issues address 0.
                    state_d   = StClear;
                    wr_n_d    = 1'b0;
                    addr_d    = clr_cnt_q[ADDR_WIDTH-1:0];
                    wdata_d   = '0;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end else begin
                    if (i_clear) begin
                        clear_pending_d = 1'b1;
                    end
                    if (grant) begin
                        last_d  = win;
                        addr_d  = i_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                        wdata_d = i_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                        wr_n_d  = ~i_we[win];
                        rd_v1_d = ~i_we[win];
                        rid1_d  = win;
                    end
                end
            end
            StClear: begin
                if (clr_cnt_q[ADDR_WIDTH]) begin
                    state_d         = StIdle;
                    clear_pending_d = 1'b0;
                    clr_cnt_d       = '0;
                end else begin
                    wr_n_d    = 1'b0;
                    addr_d    = clr_cnt_q[ADDR_WIDTH-1:0];
                    wdata_d   = '0;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q         <= StIdle;
            clear_pending_q <= 1'b0;
            last_q          <= ID_WIDTH'(NUM_REQ - 1);
            clr_cnt_q       <= '0;
            rd_v1_q         <= 1'b0;
            rid1_q          <= '0;
            o_rvalid        <= 1'b0;
            o_rid           <= '0;
            o_ram_wr_n      <= 1'b1;
            o_ram_addr      <= '0;
            o_ram_wdata     <= '0;
        end else begin
            state_q         <= state_d;
            clear_pending_q <= clear_pending_d;
            last_q          <= last_d;
            clr_cnt_q       <= clr_cnt_d;
            rd_v1_q         <= rd_v1_d;
            rid1_q          <= rid1_d;
            o_rvalid        <= rd_v1_q;
            o_rid           <= rid1_q;
            o_ram_wr_n      <= wr_n_d;
            o_ram_addr      <= addr_d;
            o_ram_wdata     <= wdata_d;
        end
    end

    assign o_busy  = clear_pending_q;
    assign o_rdata = i_ram_rdata;

endmodule
